terminal_console_writer: RTL



---
 rtl/terminal_pkg.sv | 19 +
 rtl/terminal_console_writer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/terminal_pkg.sv
// terminal_pkg: screen geometry, control characters and writer states for the console writer.
package terminal_pkg;
  localparam int COLUMNS = 80;
  localparam int ROWS = 30;
  localparam int CELL_COUNT = COLUMNS * ROWS;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_BACKSPACE = 8'h08;
  localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
  localparam logic [7:0] CHAR_RETURN = 8'h0D;
  localparam logic [7:0] CHAR_FORMFEED = 8'h0C;
  typedef enum logic [2:0] {
    IDLE,
    WRITE_CHAR,
    SCROLL_READ,
    SCROLL_WRITE,
    CLEAR_ROW,
    CLEAR_SCREEN
  } writerStateT;
endpackage

// File: rtl/terminal_console_writer.sv
// terminal_console_writer: byte stream to text buffer writer with cursor, control codes, wrap and scroll.
module terminal_console_writer #(
  parameter int COLUMNS = terminal_pkg::COLUMNS,
  parameter int ROWS = terminal_pkg::ROWS,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  charValid,
  input  logic [7:0]            charData,
  output logic                  charReady,
  output logic [ADDR_WIDTH-1:0] textAddress,
  input  logic [7:0]            textReadData,
  output logic                  shouldWriteText,
  output logic [7:0]            textWriteData,
  output logic [6:0]            cursorColumn,
  output logic [4:0]            cursorRow,
  output logic                  busy
);
  import terminal_pkg::*;
  localparam int CELLS = COLUMNS * ROWS;
  writerStateT state, stateNext;
  logic accept, lastColumn, lastRow, scrollPending, pendingNext;
  logic readyNext, busyNext, writeNext;
  logic [ADDR_WIDTH-1:0] cellAddr, addrNext;
  logic [7:0] dataNext;
  logic [6:0] columnNext;
  logic [4:0] rowNext;
  assign accept = charValid && charReady;
  assign lastColumn = cursorColumn == 7'(COLUMNS - 1);
  assign lastRow = cursorRow == 5'(ROWS - 1);
  assign cellAddr = ADDR_WIDTH'(cursorRow) * ADDR_WIDTH'(COLUMNS) + ADDR_WIDTH'(cursorColumn);
  always_comb begin
    stateNext = state;
    columnNext = cursorColumn;
    rowNext = cursorRow;
    addrNext = textAddress;
    dataNext = textWriteData;
    writeNext = 1'b0;
    pendingNext = scrollPending;
    case (state)
      IDLE: if (accept) begin
        if (charData == CHAR_RETURN) begin
          columnNext = '0;
        end else if (charData == CHAR_NEWLINE) begin
          columnNext = '0;
          if (lastRow) begin
            stateNext = SCROLL_READ;
            addrNext = ADDR_WIDTH'(COLUMNS);
          end else rowNext = cursorRow + 5'd1;
        end else if (charData == CHAR_BACKSPACE) begin
          if (cursorColumn != '0) begin
            columnNext = cursorColumn - 7'd1;
            stateNext = WRITE_CHAR;
            addrNext = cellAddr - ADDR_WIDTH'(1);
            dataNext = CHAR_SPACE;
            writeNext = 1'b1;
          end
        end else if (charData == CHAR_FORMFEED) begin
          stateNext = CLEAR_SCREEN;
          addrNext = '0;
          dataNext = CHAR_SPACE;
          writeNext = 1'b1;
          columnNext = '0;
          rowNext = '0;
        end else begin
          stateNext = WRITE_CHAR;
          addrNext = cellAddr;
          dataNext = charData;
          writeNext = 1'b1;
          columnNext = lastColumn ? 7'd0 : cursorColumn + 7'd1;
          rowNext = (lastColumn && !lastRow) ? cursorRow + 5'd1 : cursorRow;
          pendingNext = lastColumn && lastRow;
        end
      end
      WRITE_CHAR: begin
        stateNext = scrollPending ? SCROLL_READ : IDLE;
        addrNext = scrollPending ? ADDR_WIDTH'(COLUMNS) : textAddress;
        pendingNext = 1'b0;
      end
      SCROLL_READ: begin
        stateNext = SCROLL_WRITE;
        addrNext = textAddress - ADDR_WIDTH'(COLUMNS);
        dataNext = textReadData;
        writeNext = 1'b1;
      end
      SCROLL_WRITE: begin
        // Last copy lands at the end of row ROWS-2; then blank the bottom row.
        if (textAddress == ADDR_WIDTH'(CELLS - COLUMNS - 1)) begin
          stateNext = CLEAR_ROW;
          addrNext = textAddress + ADDR_WIDTH'(1);
          dataNext = CHAR_SPACE;
          writeNext = 1'b1;
        end else begin
          stateNext = SCROLL_READ;
          addrNext = textAddress + ADDR_WIDTH'(COLUMNS + 1);
        end
      end
      CLEAR_ROW, CLEAR_SCREEN: begin
        stateNext = (textAddress == ADDR_WIDTH'(CELLS - 1)) ? IDLE : state;
        writeNext = stateNext != IDLE;
        addrNext = writeNext ? textAddress + ADDR_WIDTH'(1) : textAddress;
      end
      default: stateNext = IDLE;
    endcase
    readyNext = stateNext == IDLE && !accept;
    busyNext = stateNext inside {SCROLL_READ, SCROLL_WRITE, CLEAR_ROW, CLEAR_SCREEN};
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      charReady <= 1'b1;
      busy <= 1'b0;
      shouldWriteText <= 1'b0;
      textAddress <= '0;
      textWriteData <= '0;
      cursorColumn <= '0;
      cursorRow <= '0;
      scrollPending <= 1'b0;
    end else begin
      state <= stateNext;
      charReady <= readyNext;
      busy <= busyNext;
      shouldWriteText <= writeNext;
      textAddress <= addrNext;
      textWriteData <= dataNext;
      cursorColumn <= columnNext;
      cursorRow <= rowNext;
      scrollPending <= pendingNext;
    end
  end
endmodule
